truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Sequencer that exhaustively drives every input combination of a small combinational logic block, waits a programmable settle time, and captures each output into a per-output truth-table register. It sits between a control source (button logic, host, or bench) and a combinational design under test such as the 4-input/3-output practice functions. It replaces manual input stepping with a single start/done handshake and an optional built-in pass/fail check.

## Interface
- N_IN, 4: number of DUT inputs; vectors swept = 2^N_IN.
- N_OUT, 3: number of DUT outputs captured.
- SETTLE, 1: cycles each vector is held before capture; legal range 1..15.
- EXPECTED, 0: golden table, N_OUT*2^N_IN bits, same layout as table_out (used only with SWEEP_CHECK_EN).

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- abort  in  1  cancel a running sweep.
- dut_in  out  N_IN  vector driven to the DUT; bit N_IN-1 maps to input a, bit 0 to d.
- dut_out  in  N_OUT  DUT outputs; bit 0 maps to y, bit 1 to z, bit 2 to f2.
- busy  out  1  high while a sweep is running.
- done  out  1  one-cycle pulse when a sweep completes normally.
- table_out  out  N_OUT*2^N_IN  captured table; bit o*2^N_IN+v = output o for vector v.
- pass  out  1  (SWEEP_CHECK_EN only) table_out == EXPECTED, valid from done until the next start.
- fail_idx  out  N_IN  (SWEEP_CHECK_EN only) lowest vector with any mismatch; 0 when pass=1.

## Operation
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE: start=1 and abort=0 -> clear table_out, idx=0, dut_in=0, settle count=0, go to SETTLE.
- SETTLE: count increments each cycle; at count==SETTLE-1 -> CAPTURE.
- CAPTURE: write dut_out[o] into table bit o*2^N_IN+idx for all o. If idx==2^N_IN-1 -> DONE; else idx+1, dut_in=idx+1, count=0, go to SETTLE.
- DONE: done=1 for one cycle, busy=0; go to IDLE. dut_in holds the last vector.
- abort=1 in SETTLE or CAPTURE: next state IDLE, no capture in that cycle, no done pulse; table_out keeps its partial contents.
- start while busy is ignored. start and abort together in IDLE: abort wins, the block stays in IDLE.
- idx never wraps. The sweep ends at 2^N_IN-1.
- Reset values: dut_in=0, busy=0, done=0, table_out=0, pass=0, fail_idx=0, state IDLE. Reset mid-sweep discards everything immediately.

## Timing
- start is sampled at edge E0. From E0, busy=1 and dut_in=0.
- Each vector is held for SETTLE+1 cycles: SETTLE cycles in SETTLE, then one in CAPTURE.
- dut_out is sampled at the rising edge that ends the CAPTURE cycle.
- done is high for the cycle after edge E0+2^N_IN*(SETTLE+1). busy falls at that same edge.
- Defaults: done follows 32 cycles after the start edge.
- table_out and pass are stable while done=1 and remain so until the next accepted start.

## Configuration
- SWEEP_CHECK_EN defined: the block adds pass and fail_idx. Both are computed combinationally from table_out and EXPECTED, then registered when entering DONE.
- SWEEP_CHECK_EN undefined: the pass and fail_idx ports and the comparison logic are absent. All other behaviour is identical.

## Structure
- Shared package sweep_pkg holds:
  - the state encoding (IDLE/SETTLE/CAPTURE/DONE, 2 bits);
  - localparam-style helpers for N_VEC = 2^N_IN;
  - the table bit-index function o*N_VEC+v.
- One sub-module, sweep_settle_timer: load/clear and count enable inputs, a terminal-count output at SETTLE-1, and 4-bit width.
- The FSM, index register and capture logic stay in the top module.

## Test plan
- **Loopback, defaults.** dut_out=dut_in[2:0], start pulse -> table_out = {16'hF0F0, 16'hCCCC, 16'hAAAA}; done exactly 32 cycles after the start edge; busy high for 32 cycles.
- **Settle latency.** SETTLE=3 with a DUT that adds 2 cycles of delay -> every vector is captured correctly; done 64 cycles after start. With SETTLE=1 the same DUT produces wrong columns.
- **Abort.** abort during vector 5 -> IDLE on the next edge, no done; table bits for vectors 0..4 are set and bits for vectors 5..15 stay 0. A following start clears the table and completes normally.
- **Handshake edge cases.**
  - start held high for the whole sweep -> exactly one sweep, then an immediate restart after DONE.
  - start and abort together in IDLE -> busy stays 0.
- **Reset mid-sweep.** rst_n low at vector 9 -> all outputs 0 asynchronously, before the next clock edge.
- **Checker (SWEEP_CHECK_EN).**
  - Loopback with EXPECTED equal to the loopback table -> pass=1, fail_idx=0.
  - Invert dut_out[1] only for vector 6 -> pass=0, fail_idx=6.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared state encoding and table-index helpers for truth_table_sweeper.
package sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int CNT_W = 4;

    function automatic int n_vec(input int n_in);
        return 1 << n_in;
    endfunction

    // Flat position of output o for vector v in the captured table.
    function automatic int tbl_bit(input int o, input int v, input int nvec);
        return o * nvec + v;
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle-cycle counter: cleared by clr, counts while en, tc flags count == SETTLE-1.
module sweep_settle_timer
    import sweep_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive input sweeper that captures a combinational block's truth table.
// Define SWEEP_CHECK_EN to add the golden-table pass/fail_idx comparison.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 3,
    parameter int SETTLE = 1
`ifdef SWEEP_CHECK_EN
    ,
    parameter logic [N_OUT*(1<<N_IN)-1:0] EXPECTED = '0
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    output logic [N_IN-1:0]              dut_in,
    input  logic [N_OUT-1:0]             dut_out,
    output logic                         busy,
    output logic                         done,
    output logic [N_OUT*(1<<N_IN)-1:0]   table_out
`ifdef SWEEP_CHECK_EN
    ,
    output logic                         pass,
    output logic [N_IN-1:0]              fail_idx
`endif
);

    localparam int N_VEC  = n_vec(N_IN);
    localparam int TBL_W  = N_OUT * N_VEC;
    localparam int TBL_AW = $clog2(TBL_W);

    state_t           state, state_nxt;
    logic [N_IN-1:0]  idx;
    logic [TBL_W-1:0] table_nxt;
    logic             accept, capture, last, tc;

    assign last = (idx == '1);

    sweep_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != ST_SETTLE),
        .en    (state == ST_SETTLE),
        .tc    (tc)
    );

    always_comb begin
        state_nxt = state;
        table_nxt = table_out;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    accept    = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort)   state_nxt = ST_IDLE;
                else if (tc) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    capture   = 1'b1;
                    state_nxt = last ? ST_DONE : ST_SETTLE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (accept) table_nxt = '0;
        if (capture) begin
            for (int o = 0; o < N_OUT; o++) begin
                table_nxt[TBL_AW'(tbl_bit(o, int'(idx), N_VEC))] = dut_out[o];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            table_out <= '0;
        end else begin
            state     <= state_nxt;
            table_out <= table_nxt;
            if (accept)               idx <= '0;
            else if (capture && !last) idx <= idx + 1'b1;
        end
    end

    assign dut_in = idx;
    assign busy   = (state == ST_SETTLE) || (state == ST_CAPTURE);
    assign done   = (state == ST_DONE);

`ifdef SWEEP_CHECK_EN
    logic            pass_c;
    logic [N_IN-1:0] fidx_c;

    // Compare against the table as it will be after the final capture.
    always_comb begin
        pass_c = (table_nxt == EXPECTED);
        fidx_c = '0;
        for (int v = N_VEC - 1; v >= 0; v--) begin
            for (int o = 0; o < N_OUT; o++) begin
                if (table_nxt[TBL_AW'(tbl_bit(o, v, N_VEC))] != EXPECTED[TBL_AW'(tbl_bit(o, v, N_VEC))])
                    fidx_c = N_IN'(v);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass     <= 1'b0;
            fail_idx <= '0;
        end else if (accept) begin
            pass     <= 1'b0;
            fail_idx <= '0;
        end else if (capture && last) begin
            pass     <= pass_c;
            fail_idx <= fidx_c;
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: cycle model for the SETTLE=1 instance plus directed checks.
module tb_truth_table_sweeper;

    localparam int S = 1;
    localparam logic [47:0] LB = {16'hF0F0, 16'hCCCC, 16'hAAAA};

    logic        clk, rst_n, start, abort, start_b, abort_b;
    logic [1:0]  mode;
    logic [3:0]  dut_in_a, dut_in_b, d1a, d2a, d1b, d2b;
    logic [2:0]  out_a, out_b, obs;
    logic        busy_a, done_a, busy_b, done_b;
    logic [47:0] table_a, table_b;
`ifdef SWEEP_CHECK_EN
    logic        pass_a, pass_b;
    logic [3:0]  fidx_a, fidx_b;
`endif

    int n_applied = 0;
    int n_bad = 0;

    truth_table_sweeper #(.N_IN(4), .N_OUT(3), .SETTLE(S)
`ifdef SWEEP_CHECK_EN
        , .EXPECTED(LB)
`endif
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_in(dut_in_a), .dut_out(out_a), .busy(busy_a), .done(done_a),
        .table_out(table_a)
`ifdef SWEEP_CHECK_EN
        , .pass(pass_a), .fail_idx(fidx_a)
`endif
    );

    truth_table_sweeper #(.N_IN(4), .N_OUT(3), .SETTLE(3)
`ifdef SWEEP_CHECK_EN
        , .EXPECTED(LB)
`endif
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .dut_in(dut_in_b), .dut_out(out_b), .busy(busy_b), .done(done_b),
        .table_out(table_b)
`ifdef SWEEP_CHECK_EN
        , .pass(pass_b), .fail_idx(fidx_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-cycle-latency DUT stand-ins.
    always @(posedge clk) begin
        d1a <= dut_in_a; d2a <= d1a;
        d1b <= dut_in_b; d2b <= d1b;
    end
    assign out_b = d2b[2:0];

    always_comb begin
        case (mode)
            2'd1:    out_a = d2a[2:0];
            2'd2:    out_a = dut_in_a[2:0] ^ ((dut_in_a == 4'd6) ? 3'b010 : 3'b000);
            default: out_a = dut_in_a[2:0];
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: m_st 0 idle, 1 sweeping, 2 done cycle; m_ph counts cycles since the start edge.
    int          m_st = 0;
    int          m_ph = 0;
    int          mv;
    logic [3:0]  m_vec = '0;
    logic [47:0] m_tbl = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_ph = 0; m_vec = '0; m_tbl = '0;
        end else begin
            case (m_st)
                0: if (start && !abort) begin
                    m_st = 1; m_ph = 0; m_vec = '0; m_tbl = '0;
                end
                1: if (abort) begin
                    m_st = 0;
                end else begin
                    if (m_ph % (S + 1) == S) begin
                        mv = m_ph / (S + 1);
                        for (int o = 0; o < 3; o++)
                            m_tbl = m_tbl | (48'(obs[o]) << (o * 16 + mv));
                        if (mv == 15) m_st = 2;
                    end
                    m_ph++;
                    if (m_st == 1) m_vec = 4'(m_ph / (S + 1));
                end
                default: m_st = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        obs = out_a;
        chk("cyc_busy",   64'(busy_a),   64'(m_st == 1));
        chk("cyc_done",   64'(done_a),   64'(m_st == 2));
        chk("cyc_dut_in", 64'(dut_in_a), 64'(m_vec));
        chk("cyc_table",  64'(table_a),  64'(m_tbl));
    end

    task automatic wait_done(input bit drop, output int lat, output int bz);
        lat = -1; bz = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1 && drop) start = 1'b0;
            if (busy_a) bz++;
            if (done_a) begin lat = k - 1; break; end
        end
    endtask

    task automatic run_a(input logic [1:0] md, input logic [47:0] exp_tbl, input string nm);
        int lat, bz;
        mode = md;
        @(negedge clk);
        start = 1'b1;
        wait_done(1'b1, lat, bz);
        chk({nm, "_latency"}, 64'(lat), 64'd32);
        chk({nm, "_busy_cycles"}, 64'(bz), 64'd32);
        chk({nm, "_table"}, 64'(table_a), 64'(exp_tbl));
    endtask

    task automatic wait_vec(input logic [3:0] v, input string nm);
        bit hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (dut_in_a == v) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        chk({nm, "_reach"}, 64'(hit), 64'd1);
    endtask

    initial begin
        int lat, bz;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start_b = 1'b0; abort_b = 1'b0; mode = 2'd0;
        #12;
        chk("rst_busy",  64'(busy_a),   64'd0);
        chk("rst_done",  64'(done_a),   64'd0);
        chk("rst_dut_in", 64'(dut_in_a), 64'd0);
        chk("rst_table", 64'(table_a),  64'd0);
        chk("rst_table_b", 64'(table_b), 64'd0);
`ifdef SWEEP_CHECK_EN
        chk("rst_pass", 64'(pass_a), 64'd0);
        chk("rst_fidx", 64'(fidx_a), 64'd0);
`endif
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_a(2'd0, LB, "loopback");
        chk("loopback_last_vec", 64'(dut_in_a), 64'd15);
`ifdef SWEEP_CHECK_EN
        chk("loopback_pass", 64'(pass_a), 64'd1);
        chk("loopback_fidx", 64'(fidx_a), 64'd0);
`endif

        // SETTLE=3 instance with the delayed DUT.
        @(negedge clk);
        start_b = 1'b1;
        lat = -1; bz = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) start_b = 1'b0;
            if (busy_b) bz++;
            if (done_b) begin lat = k - 1; break; end
        end
        chk("settle3_latency", 64'(lat), 64'd64);
        chk("settle3_busy_cycles", 64'(bz), 64'd64);
        chk("settle3_table", 64'(table_b), 64'(LB));
`ifdef SWEEP_CHECK_EN
        chk("settle3_pass", 64'(pass_b), 64'd1);
`endif

        // SETTLE=1 with the delayed DUT captures the previous vector.
        run_a(2'd1, {16'hE1E1, 16'h9999, 16'h5555}, "settle1_delayed");

        // Abort during vector 5.
        mode = 2'd0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_vec(4'd5, "abort");
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_busy", 64'(busy_a), 64'd0);
        for (int k = 0; k < 3; k++) begin
            chk("abort_no_done", 64'(done_a), 64'd0);
            @(negedge clk);
        end
        chk("abort_partial_table", 64'(table_a), 64'({16'h0010, 16'h000C, 16'h000A}));
        run_a(2'd0, LB, "after_abort");

        // One faulty vector.
        run_a(2'd2, {16'hF0F0, 16'hCC8C, 16'hAAAA}, "fault_v6");
`ifdef SWEEP_CHECK_EN
        chk("fault_pass", 64'(pass_a), 64'd0);
        chk("fault_fidx", 64'(fidx_a), 64'd6);
`endif
        mode = 2'd0;

        // Start held high across a whole sweep.
        @(negedge clk); start = 1'b1;
        wait_done(1'b0, lat, bz);
        chk("held_latency", 64'(lat), 64'd32);
        chk("held_busy_cycles", 64'(bz), 64'd32);
        @(negedge clk);
        chk("held_idle_gap", 64'(busy_a), 64'd0);
        @(negedge clk);
        chk("held_restart", 64'(busy_a), 64'd1);
        start = 1'b0; abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("held_abort", 64'(busy_a), 64'd0);

        // start and abort together in IDLE.
        @(negedge clk); start = 1'b1; abort = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("start_abort_idle", 64'(busy_a), 64'd0);
        end
        start = 1'b0; abort = 1'b0;

        // Reset at vector 9.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_vec(4'd9, "reset_mid");
        #2 rst_n = 1'b0;
        #1;
        chk("reset_mid_dut_in", 64'(dut_in_a), 64'd0);
        chk("reset_mid_busy",   64'(busy_a),   64'd0);
        chk("reset_mid_done",   64'(done_a),   64'd0);
        chk("reset_mid_table",  64'(table_a),  64'd0);
`ifdef SWEEP_CHECK_EN
        chk("reset_mid_pass", 64'(pass_a), 64'd0);
        chk("reset_mid_fidx", 64'(fidx_a), 64'd0);
`endif
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_a(2'd0, LB, "post_reset");

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_bad);
        $finish;
    end

endmodule
